tpu_tile_sched: RTL and testbench

//  Sequences the TPU over a GEMM larger than one TPU run. Takes total K/M/N from the CFU command decoder.

---
 rtl/tpu_sched_pkg.sv | 18 +
 rtl/tpu_tile_sched_if.sv | 46 ++++
 rtl/tile_addr_gen.sv | 59 +++++
 rtl/tpu_tile_sched.sv | 165 ++++++++++++++++
 tb/tb_tpu_tile_sched.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_sched_pkg.sv
// Shared state encoding and default widths for the TPU tile scheduler.
package tpu_sched_pkg;

   localparam int DEF_DIM_BITS  = 32;
   localparam int DEF_ADDR_BITS = 12;
   localparam int TPU_LANES     = 4;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SETUP     = 3'd1,
      LAUNCH    = 3'd2,
      WAIT_BUSY = 3'd3,
      WAIT_DONE = 3'd4,
      ADVANCE   = 3'd5,
      DONE      = 3'd6
   } sched_state_e;

endpackage

// File: rtl/tpu_tile_sched_if.sv
// Command-side and TPU-side signals of the tile scheduler.
// TILE_SCHED_PERF_EN adds the perf_tiles / perf_busy_cyc counters.
interface tpu_tile_sched_if
   import tpu_sched_pkg::*;
#(
   parameter int DIM_BITS  = DEF_DIM_BITS,
   parameter int ADDR_BITS = DEF_ADDR_BITS
);
   logic                 start;
   logic [DIM_BITS-1:0]  cfg_K, cfg_M, cfg_N;
   logic                 sched_busy;
   logic                 done;
   logic                 err;
   logic                 tpu_in_valid;
   logic [DIM_BITS-1:0]  tpu_K, tpu_M, tpu_N;
   logic [ADDR_BITS-1:0] a_base, b_base, c_base;
   logic                 tpu_busy;

`ifdef TILE_SCHED_PERF_EN
   logic [15:0] perf_tiles;
   logic [31:0] perf_busy_cyc;

   modport slave (
      input  start, cfg_K, cfg_M, cfg_N, tpu_busy,
      output sched_busy, done, err, tpu_in_valid, tpu_K, tpu_M, tpu_N,
             a_base, b_base, c_base, perf_tiles, perf_busy_cyc
   );
   modport master (
      output start, cfg_K, cfg_M, cfg_N, tpu_busy,
      input  sched_busy, done, err, tpu_in_valid, tpu_K, tpu_M, tpu_N,
             a_base, b_base, c_base, perf_tiles, perf_busy_cyc
   );
`else
   modport slave (
      input  start, cfg_K, cfg_M, cfg_N, tpu_busy,
      output sched_busy, done, err, tpu_in_valid, tpu_K, tpu_M, tpu_N,
             a_base, b_base, c_base
   );
   modport master (
      output start, cfg_K, cfg_M, cfg_N, tpu_busy,
      input  sched_busy, done, err, tpu_in_valid, tpu_K, tpu_M, tpu_N,
             a_base, b_base, c_base
   );
`endif

endinterface

// File: rtl/tile_addr_gen.sv
// Combinational tile geometry: clipped edge-tile dims, A/B/C base indices,
// base overflow and last-tile flags, all computed in DIM_BITS+ADDR_BITS.
module tile_addr_gen
   import tpu_sched_pkg::*;
#(
   parameter int DIM_BITS  = DEF_DIM_BITS,
   parameter int ADDR_BITS = DEF_ADDR_BITS,
   parameter int TILE_M    = 64,
   parameter int TILE_N    = 64
) (
   input  logic [DIM_BITS-1:0]  m_idx,
   input  logic [DIM_BITS-1:0]  n_idx,
   input  logic [DIM_BITS-1:0]  tile_seq,
   input  logic [DIM_BITS-1:0]  dim_k,
   input  logic [DIM_BITS-1:0]  dim_m,
   input  logic [DIM_BITS-1:0]  dim_n,
   output logic [DIM_BITS-1:0]  tile_m,
   output logic [DIM_BITS-1:0]  tile_n,
   output logic [ADDR_BITS-1:0] a_base,
   output logic [ADDR_BITS-1:0] b_base,
   output logic [ADDR_BITS-1:0] c_base,
   output logic                 overflow,
   output logic                 last_m,
   output logic                 last_n
);
   localparam int W = DIM_BITS + ADDR_BITS;

   logic [W-1:0] m_off, n_off, m_rem, n_rem;
   logic [W-1:0] base_full [3];
   logic [2:0]   base_ovf;

   assign m_off = W'(m_idx) * W'(TILE_M);
   assign n_off = W'(n_idx) * W'(TILE_N);
   assign m_rem = W'(dim_m) - m_off;
   assign n_rem = W'(dim_n) - n_off;

   assign tile_m = (m_rem < W'(TILE_M)) ? m_rem[DIM_BITS-1:0] : DIM_BITS'(TILE_M);
   assign tile_n = (n_rem < W'(TILE_N)) ? n_rem[DIM_BITS-1:0] : DIM_BITS'(TILE_N);

   assign last_m = (m_off + W'(TILE_M)) >= W'(dim_m);
   assign last_n = (n_off + W'(TILE_N)) >= W'(dim_n);

   // Products are taken before the divide by the lane count so truncation matches the full-width formula.
   assign base_full[0] = (W'(m_idx) * W'(dim_k) * W'(TILE_M)) / W'(TPU_LANES);
   assign base_full[1] = (W'(n_idx) * W'(dim_k) * W'(TILE_N)) / W'(TPU_LANES);
   assign base_full[2] = (W'(tile_seq) * W'(TILE_M) * W'(TILE_N)) / W'(TPU_LANES);

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_ovf
         assign base_ovf[gi] = |base_full[gi][W-1:ADDR_BITS];
      end
   endgenerate

   assign a_base   = base_full[0][ADDR_BITS-1:0];
   assign b_base   = base_full[1][ADDR_BITS-1:0];
   assign c_base   = base_full[2][ADDR_BITS-1:0];
   assign overflow = |base_ovf;

endmodule

// File: rtl/tpu_tile_sched.sv
// Splits a K x M x N GEMM into TILE_M x TILE_N TPU runs (M outer, N inner, K whole).
// Define TILE_SCHED_PERF_EN for tile / busy-cycle performance counters.
module tpu_tile_sched
   import tpu_sched_pkg::*;
#(
   parameter int DIM_BITS     = DEF_DIM_BITS,
   parameter int ADDR_BITS    = DEF_ADDR_BITS,
   parameter int TILE_M       = 64,
   parameter int TILE_N       = 64,
   parameter int BUSY_TIMEOUT = 1023
) (
   input  logic            clk,
   input  logic            rst_n,
   tpu_tile_sched_if.slave bus
);
   localparam int CNT_BITS = $clog2(BUSY_TIMEOUT + 1);

   sched_state_e         state_reg, state_next;
   logic [DIM_BITS-1:0]  k_reg, m_reg, n_reg;
   logic [DIM_BITS-1:0]  m_idx_reg, n_idx_reg, seq_reg;
   logic [DIM_BITS-1:0]  tpu_k_reg, tpu_m_reg, tpu_n_reg;
   logic [ADDR_BITS-1:0] a_base_reg, b_base_reg, c_base_reg;
   logic [CNT_BITS-1:0]  wait_cnt_reg;
   logic                 err_reg;

   logic [DIM_BITS-1:0]  tile_m, tile_n;
   logic [ADDR_BITS-1:0] a_base, b_base, c_base;
   logic                 overflow, last_m, last_n, dims_zero, timeout_hit;

   tile_addr_gen #(
      .DIM_BITS (DIM_BITS),
      .ADDR_BITS(ADDR_BITS),
      .TILE_M   (TILE_M),
      .TILE_N   (TILE_N)
   ) u_addr_gen (
      .m_idx   (m_idx_reg),
      .n_idx   (n_idx_reg),
      .tile_seq(seq_reg),
      .dim_k   (k_reg),
      .dim_m   (m_reg),
      .dim_n   (n_reg),
      .tile_m  (tile_m),
      .tile_n  (tile_n),
      .a_base  (a_base),
      .b_base  (b_base),
      .c_base  (c_base),
      .overflow(overflow),
      .last_m  (last_m),
      .last_n  (last_n)
   );

   assign dims_zero   = (k_reg == '0) || (m_reg == '0) || (n_reg == '0);
   assign timeout_hit = (wait_cnt_reg == CNT_BITS'(BUSY_TIMEOUT - 1));

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:      if (bus.start) state_next = SETUP;
         SETUP:     state_next = (dims_zero || overflow) ? DONE : LAUNCH;
         LAUNCH:    state_next = WAIT_BUSY;
         WAIT_BUSY: if (bus.tpu_busy) state_next = WAIT_DONE;
                    else if (timeout_hit) state_next = DONE;
         WAIT_DONE: if (!bus.tpu_busy) state_next = ADVANCE;
         ADVANCE:   state_next = (last_m && last_n) ? DONE : SETUP;
         DONE:      state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         k_reg        <= '0;
         m_reg        <= '0;
         n_reg        <= '0;
         m_idx_reg    <= '0;
         n_idx_reg    <= '0;
         seq_reg      <= '0;
         tpu_k_reg    <= '0;
         tpu_m_reg    <= '0;
         tpu_n_reg    <= '0;
         a_base_reg   <= '0;
         b_base_reg   <= '0;
         c_base_reg   <= '0;
         wait_cnt_reg <= '0;
         err_reg      <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: if (bus.start) begin
               k_reg     <= bus.cfg_K;
               m_reg     <= bus.cfg_M;
               n_reg     <= bus.cfg_N;
               m_idx_reg <= '0;
               n_idx_reg <= '0;
               seq_reg   <= '0;
               err_reg   <= 1'b0;
            end
            // Tile outputs only change here, so they stay stable for the whole TPU run.
            SETUP: if (!dims_zero) begin
               if (overflow) begin
                  err_reg <= 1'b1;
               end else begin
                  tpu_k_reg  <= k_reg;
                  tpu_m_reg  <= tile_m;
                  tpu_n_reg  <= tile_n;
                  a_base_reg <= a_base;
                  b_base_reg <= b_base;
                  c_base_reg <= c_base;
               end
            end
            LAUNCH: wait_cnt_reg <= '0;
            WAIT_BUSY: if (!bus.tpu_busy) begin
               if (timeout_hit) err_reg <= 1'b1;
               else             wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
            ADVANCE: begin
               seq_reg <= seq_reg + 1'b1;
               if (last_n) begin
                  n_idx_reg <= '0;
                  m_idx_reg <= m_idx_reg + 1'b1;
               end else begin
                  n_idx_reg <= n_idx_reg + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.sched_busy   = (state_reg != IDLE);
   assign bus.done         = (state_reg == DONE);
   assign bus.err          = err_reg;
   assign bus.tpu_in_valid = (state_reg == LAUNCH);
   assign bus.tpu_K        = tpu_k_reg;
   assign bus.tpu_M        = tpu_m_reg;
   assign bus.tpu_N        = tpu_n_reg;
   assign bus.a_base       = a_base_reg;
   assign bus.b_base       = b_base_reg;
   assign bus.c_base       = c_base_reg;

`ifdef TILE_SCHED_PERF_EN
   logic [15:0] perf_tiles_reg;
   logic [31:0] perf_busy_cyc_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_tiles_reg    <= '0;
         perf_busy_cyc_reg <= '0;
      end else if (state_reg == IDLE && bus.start) begin
         perf_tiles_reg    <= '0;
         perf_busy_cyc_reg <= '0;
      end else begin
         if (state_reg == ADVANCE && perf_tiles_reg != '1)
            perf_tiles_reg <= perf_tiles_reg + 1'b1;
         if (state_reg != IDLE && bus.tpu_busy && perf_busy_cyc_reg != '1)
            perf_busy_cyc_reg <= perf_busy_cyc_reg + 1'b1;
      end
   end

   assign bus.perf_tiles    = perf_tiles_reg;
   assign bus.perf_busy_cyc = perf_busy_cyc_reg;
`endif

endmodule

// File: tb/tb_tpu_tile_sched.sv
// Bench for tpu_tile_sched: expected tile launches are queued at job start and
// popped when tpu_in_valid fires; job-level results are checked after done.
module tb_tpu_tile_sched;

   typedef struct {
      logic [31:0] k, m, n;
      logic [11:0] a, b, c;
   } tile_t;

   tile_t exp_q[$];
   tile_t exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0, n_err = 0;
   int   cyc = 0, n_launch = 0, n_done = 0;
   int   launch_cyc = 0, done_cyc = 0, start_cyc = 0;
   bit   tpu_never = 1'b0;
   int   busy_cnt = 0;

   tpu_tile_sched_if #(.DIM_BITS(32), .ADDR_BITS(12)) bus ();

   tpu_tile_sched #(
      .DIM_BITS    (32),
      .ADDR_BITS   (12),
      .TILE_M      (64),
      .TILE_N      (64),
      .BUSY_TIMEOUT(1023)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // TPU model: busy for 10 cycles starting the half-cycle after a launch.
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_cnt     = 0;
         bus.tpu_busy = 1'b0;
      end else begin
         if (bus.tpu_in_valid && !tpu_never) busy_cnt = 10;
         bus.tpu_busy = (busy_cnt > 0);
         if (busy_cnt > 0) busy_cnt--;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.tpu_in_valid) begin
            n_launch++;
            launch_cyc = cyc;
            $display("[%0d] launch K=%0d M=%0d N=%0d a=%0d b=%0d c=%0d", cyc, bus.tpu_K,
                     bus.tpu_M, bus.tpu_N, bus.a_base, bus.b_base, bus.c_base);
            if (exp_q.size() == 0) begin
               check("unexpected_launch", 1, 0);
            end else begin
               exp_t = exp_q.pop_front();
               check("tpu_K", bus.tpu_K, exp_t.k);
               check("tpu_M", bus.tpu_M, exp_t.m);
               check("tpu_N", bus.tpu_N, exp_t.n);
               check("a_base", bus.a_base, exp_t.a);
               check("b_base", bus.b_base, exp_t.b);
               check("c_base", bus.c_base, exp_t.c);
            end
         end
         if (bus.done) begin
            n_done++;
            done_cyc = cyc;
            $display("[%0d] done err=%0b", cyc, bus.err);
         end
      end
   end

   task automatic push_tile(input logic [31:0] k, m, n, input logic [11:0] a, b, c);
      tile_t t;
      t.k = k; t.m = m; t.n = n; t.a = a; t.b = b; t.c = c;
      exp_q.push_back(t);
   endtask

   task automatic start_job(input logic [31:0] k, m, n);
      @(negedge clk);
      bus.cfg_K = k;
      bus.cfg_M = m;
      bus.cfg_N = n;
      bus.start = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int bound);
      int t = 0;
      while (n_done == d0 && t < bound) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (n_done == d0) check("done_timeout", 0, 1);
   endtask

   task automatic run_job(input logic [31:0] k, m, n, input int exp_tiles,
                          input logic exp_err, input string name);
      int l0 = n_launch;
      int d0 = n_done;
      start_job(k, m, n);
      wait_done(d0, 3000);
      check({name, "_err"}, bus.err, exp_err);
      check({name, "_tiles"}, n_launch - l0, exp_tiles);
      check({name, "_qleft"}, exp_q.size(), 0);
      @(negedge clk);
      #1;
      check({name, "_busy_after"}, bus.sched_busy, 0);
      check({name, "_done_cnt"}, n_done - d0, 1);
   endtask

   task automatic push_t2();
      push_tile(8, 64, 64, 0, 0, 0);
      push_tile(8, 64, 6, 0, 128, 1024);
      push_tile(8, 36, 64, 128, 0, 2048);
      push_tile(8, 36, 6, 128, 128, 3072);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected fewer", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int l0, d0, t;
      bus.start = 1'b0;
      bus.cfg_K = '0;
      bus.cfg_M = '0;
      bus.cfg_N = '0;

      repeat (3) @(negedge clk);
      check("rst_sched_busy", bus.sched_busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.err, 0);
      check("rst_in_valid", bus.tpu_in_valid, 0);
      check("rst_tpu_M", bus.tpu_M, 0);
      check("rst_c_base", bus.c_base, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single full tile
      push_tile(8, 64, 64, 0, 0, 0);
      run_job(8, 64, 64, 1, 1'b0, "t1");
      check("t1_launch_latency", launch_cyc - start_cyc, 2);
`ifdef TILE_SCHED_PERF_EN
      check("t1_perf_tiles", bus.perf_tiles, 1);
      check("t1_perf_busy_cyc", bus.perf_busy_cyc, 10);
`endif

      // 2x2 tiles with partial edges
      push_t2();
      run_job(8, 100, 70, 4, 1'b0, "t2");

      // busy never rises: timeout
      tpu_never = 1'b1;
      push_tile(8, 64, 64, 0, 0, 0);
      run_job(8, 64, 64, 1, 1'b1, "t3");
      check("t3_timeout_cycles", done_cyc - launch_cyc, 1024);
      tpu_never = 1'b0;

      // zero dimension: no tiles, err cleared by the accepted start
      l0 = n_launch;
      d0 = n_done;
      start_job(8, 0, 64);
      #1;
      check("t4_err_cleared", bus.err, 0);
      wait_done(d0, 100);
      check("t4_done_latency", done_cyc - start_cyc, 2);
      check("t4_tiles", n_launch - l0, 0);
      check("t4_err", bus.err, 0);

      // async reset during the second tile
      push_t2();
      l0 = n_launch;
      d0 = n_done;
      start_job(8, 100, 70);
      t = 0;
      while (n_launch < l0 + 2 && t < 200) begin
         @(negedge clk);
         #1;
         t++;
      end
      check("t5_reached_tile2", n_launch - l0, 2);
      repeat (4) @(negedge clk);
      check("t5_pre_rst_busy", bus.sched_busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_arst_busy", bus.sched_busy, 0);
      check("t5_arst_tpu_M", bus.tpu_M, 0);
      check("t5_arst_tpu_N", bus.tpu_N, 0);
      check("t5_arst_c_base", bus.c_base, 0);
      check("t5_arst_in_valid", bus.tpu_in_valid, 0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("t5_no_done", n_done - d0, 0);
      push_t2();
      run_job(8, 100, 70, 4, 1'b0, "t5_rerun");

      // c_base overflow on the fifth tile; mid-job starts ignored
      for (int i = 0; i < 4; i++) push_tile(64, 64, 64, 0, 12'(i * 1024), 12'(i * 1024));
      l0 = n_launch;
      d0 = n_done;
      start_job(64, 256, 256);
      repeat (3) @(negedge clk);
      bus.cfg_M = 64;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (20) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(d0, 3000);
      check("t6_err", bus.err, 1);
      check("t6_tiles", n_launch - l0, 4);
      check("t6_qleft", exp_q.size(), 0);
      repeat (5) @(negedge clk);
      #1;
      check("t6_done_cnt", n_done - d0, 1);
      check("t6_idle_after", bus.sched_busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
